// File: rtl/team_06_echo_pkg.sv
// Shared types and helpers for the echo/delay line: FSM state encoding and a
// width-parameterised saturating clamp.
package team_06_echo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MIX  = 2'd2,
    WR   = 2'd3
  } echo_state_e;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                  input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/team_06_echo_delay_line_mixer.sv
// Combinational echo mixer: past * gain / 2**GAIN_W added to the dry sample,
// then clamped to the signed DATA_W range.
module team_06_echo_mixer
  import team_06_echo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 4
) (
  input  logic signed [DATA_W-1:0] audio_i,
  input  logic signed [DATA_W-1:0] past_i,
  input  logic        [GAIN_W-1:0] gain_i,
  output logic signed [DATA_W-1:0] mix_o
);

  localparam int PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0]     past_x;
  logic signed [PW-1:0]     gain_x;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     scaled;
  logic signed [DATA_W:0]   sum;
  logic signed [31:0]       sum_ext;

  assign past_x  = PW'(past_i);
  assign gain_x  = PW'($signed({1'b0, gain_i}));
  assign prod    = past_x * gain_x;
  // Gain is strictly below 1.0, so the scaled value always fits in DATA_W bits.
  assign scaled  = prod >>> GAIN_W;
  assign sum     = (DATA_W+1)'(audio_i) + (DATA_W+1)'(scaled);
  assign sum_ext = 32'(sum);
  assign mix_o   = DATA_W'(saturate(sum_ext, DATA_W));

endmodule

// File: rtl/team_06_echo_delay_line.sv
// Echo/delay effect: per sample, read the delayed tap, mix it, then write back
// to a circular delay line. Define TEAM_06_ECHO_FEEDBACK_EN to write the wet
// (mixed) sample instead of the dry one, giving a repeating decaying echo.
//
// state | meaning
// IDLE  | waiting for sample_valid; latches sample and settings
// RD    | reading delayed tap at wr_ptr - delay, held until mem_ack
// MIX   | registering the mixed output
// WR    | writing the new sample at wr_ptr, held until mem_ack
module team_06_echo_delay_line
  import team_06_echo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int GAIN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic                     echo_enable,
  input  logic        [ADDR_W-1:0] delay,
  input  logic        [GAIN_W-1:0] gain,
  output logic        [ADDR_W-1:0] mem_addr,
  output logic                     mem_rd_req,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     mem_wr_req,
  output logic signed [DATA_W-1:0] mem_wr_data,
  input  logic                     mem_ack,
  output logic signed [DATA_W-1:0] echo_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

  echo_state_e              state_q,     state_d;
  logic signed [DATA_W-1:0] in_q,        in_d;
  logic                     en_q,        en_d;
  logic        [ADDR_W-1:0] delay_q,     delay_d;
  logic        [GAIN_W-1:0] gain_q,      gain_d;
  logic signed [DATA_W-1:0] past_q,      past_d;
  logic signed [DATA_W-1:0] echo_q,      echo_d;
  logic                     out_valid_q, out_valid_d;
  logic        [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic        [ADDR_W:0]   fill_q,      fill_d;
  logic                     overrun_q,   overrun_d;

  logic signed [DATA_W-1:0] past_mix;
  logic signed [DATA_W-1:0] mix_out;

  assign past_mix = en_q ? past_q : '0;

  team_06_echo_mixer #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_mixer (
    .audio_i (in_q),
    .past_i  (past_mix),
    .gain_i  (gain_q),
    .mix_o   (mix_out)
  );

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    en_d        = en_q;
    delay_d     = delay_q;
    gain_d      = gain_q;
    past_d      = past_q;
    echo_d      = echo_q;
    out_valid_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          in_d    = audio_in;
          en_d    = echo_enable;
          delay_d = delay;
          gain_d  = gain;
          state_d = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          // Locations not yet written since reset must never reach the mix.
          if (delay_q == '0 || {1'b0, delay_q} > fill_q) begin
            past_d = '0;
          end else begin
            past_d = mem_rd_data;
          end
          state_d = MIX;
        end
      end
      MIX: begin
        echo_d      = mix_out;
        out_valid_d = 1'b1;
        state_d     = WR;
      end
      WR: begin
        if (mem_ack) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sample_valid && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      en_q        <= 1'b0;
      delay_q     <= '0;
      gain_q      <= '0;
      past_q      <= '0;
      echo_q      <= '0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      en_q        <= en_d;
      delay_q     <= delay_d;
      gain_q      <= gain_d;
      past_q      <= past_d;
      echo_q      <= echo_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_rd_req = (state_q == RD);
  assign mem_wr_req = (state_q == WR);
  assign mem_addr   = (state_q == RD) ? (wr_ptr_q - delay_q) : wr_ptr_q;
  assign busy       = (state_q != IDLE);
  assign echo_out   = echo_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

`ifdef TEAM_06_ECHO_FEEDBACK_EN
  // With echo disabled echo_q equals the dry sample, so the write stays dry.
  assign mem_wr_data = en_q ? echo_q : in_q;
`else
  assign mem_wr_data = in_q;
`endif

endmodule

// File: tb/tb_team_06_echo_delay_line.sv
// Scoreboard bench for team_06_echo_delay_line with an 8-entry delay line;
// honours TEAM_06_ECHO_FEEDBACK_EN in its reference model.
module tb_team_06_echo_delay_line;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int GW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_valid;
  logic signed [DW-1:0] audio_in;
  logic                 echo_enable;
  logic        [AW-1:0] delay;
  logic        [GW-1:0] gain;
  logic        [AW-1:0] mem_addr;
  logic                 mem_rd_req;
  logic signed [DW-1:0] mem_rd_data;
  logic                 mem_wr_req;
  logic signed [DW-1:0] mem_wr_data;
  logic                 mem_ack;
  logic signed [DW-1:0] echo_out;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;

  team_06_echo_delay_line #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .GAIN_W (GW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .echo_enable  (echo_enable),
    .delay        (delay),
    .gain         (gain),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_data  (mem_wr_data),
    .mem_ack      (mem_ack),
    .echo_out     (echo_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int outs = 0;
  int accepted = 0;
  int n_wr = 0;
  int wait_cnt = 0;
  int ack_wait = 0;
  int hist [0:255];
  logic signed [DW-1:0] mem [DEPTH];
  int exp_out_q [$];
  int exp_rd_q [$];
  int exp_wr_q [$];
  int exp_wd_q [$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic push_expect(input int in, input bit en, input int d, input int g);
    int fill;
    int past;
    int out;
    int wd;
    fill = (n_wr > DEPTH) ? DEPTH : n_wr;
    past = (d == 0 || d > fill) ? 0 : hist[n_wr - d];
    out  = en ? sat8(in + ((past * g) >>> GW)) : in;
    wd   = in;
`ifdef TEAM_06_ECHO_FEEDBACK_EN
    if (en) wd = out;
`endif
    exp_out_q.push_back(out);
    exp_rd_q.push_back((n_wr - d) & (DEPTH - 1));
    exp_wr_q.push_back(n_wr & (DEPTH - 1));
    exp_wd_q.push_back(wd);
    hist[n_wr] = wd;
    n_wr++;
    accepted++;
  endtask

  // Called once per negedge: memory responder plus output scoreboard.
  task automatic service();
    mem_ack = 1'b0;
    if (out_valid) begin
      outs++;
      if (exp_out_q.size() == 0) check("out_extra", 1, 0);
      else check("echo_out", int'(echo_out), exp_out_q.pop_front());
    end
    if (mem_rd_req || mem_wr_req) begin
      if (wait_cnt < ack_wait) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mem_ack  = 1'b1;
        if (mem_rd_req) begin
          if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
          else check("rd_addr", int'(mem_addr), exp_rd_q.pop_front());
          mem_rd_data = mem[mem_addr];
        end else begin
          if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
          else begin
            check("wr_addr", int'(mem_addr), exp_wr_q.pop_front());
            check("wr_data", int'(mem_wr_data), exp_wd_q.pop_front());
          end
          mem[mem_addr] = mem_wr_data;
        end
      end
    end else begin
      wait_cnt = 0;
      mem_ack  = busy;  // stray ack with no request outstanding
    end
  endtask

  task automatic send(input int in, input bit en, input int d, input int g,
                      input int aw, input bit intrude);
    int  cnt;
    bit  poked;
    ack_wait = aw;
    push_expect(in, en, d, g);
    sample_valid = 1'b1;
    audio_in     = DW'(in);
    echo_enable  = en;
    delay        = AW'(d);
    gain         = GW'(g);
    @(negedge clk);
    service();
    sample_valid = 1'b0;
    cnt   = 0;
    poked = 1'b0;
    while (busy && cnt < 60) begin
      @(negedge clk);
      service();
      if (intrude && !poked && mem_wr_req) begin
        sample_valid = 1'b1;
        audio_in     = 8'sd55;
        poked        = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      cnt++;
    end
    sample_valid = 1'b0;
    if (busy) check("timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    exp_out_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_wd_q.delete();
    n_wr     = 0;
    wait_cnt = 0;
    ack_wait = 0;
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    audio_in     = '0;
    echo_enable  = 1'b0;
    delay        = '0;
    gain         = '0;
    mem_rd_data  = '0;
    mem_ack      = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_req", int'(mem_rd_req), 0);
    check("rst_wr_req", int'(mem_wr_req), 0);
    check("rst_echo", int'(echo_out), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_addr", int'(mem_addr), 0);
    do_reset();

    // Basic echo: delay 2, gain 1/2
    send(40, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
    check("basic_third", int'(echo_out), 20);

    // Saturation, positive then negative
    send(100, 1, 1, 0, 0, 0);
    send(100, 1, 1, 15, 0, 0);
    check("sat_pos", int'(echo_out), 127);
    send(-100, 1, 1, 0, 0, 0);
    send(-100, 1, 1, 15, 0, 0);
    check("sat_neg", int'(echo_out), -128);
    check("no_overrun_yet", int'(overrun), 0);

    // Overrun during a slow write; out_valid must still pulse once
    send(12, 1, 1, 4, 3, 1);
    check("overrun_set", int'(overrun), 1);
    send(-7, 1, 2, 4, 1, 0);
    check("overrun_sticky", int'(overrun), 1);
    check("out_count_mid", outs, accepted);

    // Asynchronous reset while a read is stalled
    ack_wait     = 1000;
    sample_valid = 1'b1;
    audio_in     = 8'sd9;
    delay        = 3'd1;
    @(negedge clk);
    service();
    sample_valid = 1'b0;
    check("rd_stalled", int'(mem_rd_req), 1);
    rst = 1'b1;
    #1;
    check("arst_rd_req", int'(mem_rd_req), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_echo", int'(echo_out), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    do_reset();

    // Unwritten memory must not be mixed; zero delay and dry path
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'sd77;
    send(33, 1, 5, 15, 0, 0);
    check("fill_guard", int'(echo_out), 33);
    send(-20, 1, 0, 15, 0, 0);
    check("zero_delay", int'(echo_out), -20);
    send(50, 0, 1, 15, 0, 0);
    check("dry_path", int'(echo_out), 50);

    // Pointer wrap and fill saturation
    do_reset();
    for (int i = 0; i < 10; i++) send(i * 7 - 30, 1, 3, 4, 0, 0);
    send(25, 1, 7, 12, 0, 0);

    // Repeating echo sequence (single tap when feedback is off)
    do_reset();
    send(40, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
    send(0, 1, 2, 8, 0, 0);
`ifdef TEAM_06_ECHO_FEEDBACK_EN
    check("feedback_tail", int'(echo_out), 10);
`else
    check("single_tap_tail", int'(echo_out), 0);
`endif

    check("out_count", outs, accepted);
    check("scoreboard_empty", exp_out_q.size() + exp_rd_q.size() + exp_wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
